// File: rtl/cpu_mem_responder_pkg.sv
// Shared Cpu bus types for the memory responder: request sizes, responder FSM states and helpers.
// The optional misalignment fault is enabled by CPU_MEM_RESP_ALIGN_FAULT_EN.
package pkg_cpu;

    typedef enum logic [1:0] {
        ReqDataSz8  = 2'd0,
        ReqDataSz16 = 2'd1,
        ReqDataSz32 = 2'd2,
        ReqDataSz48 = 2'd3
    } ReqDataSz;

    typedef enum logic [1:0] {
        MemRespIdle = 2'd0,
        MemRespWait = 2'd1,
        MemRespXfer = 2'd2,
        MemRespDone = 2'd3
    } MemRespState;

    localparam int mem_resp_rdata_width = 48;

    function automatic logic [2:0] req_size_to_bytes(input ReqDataSz size);
        case (size)
            ReqDataSz8:  return 3'd1;
            ReqDataSz16: return 3'd2;
            ReqDataSz32: return 3'd4;
            default:     return 3'd6;
        endcase
    endfunction

    // 48b fetches only need even alignment; 32b accesses need word alignment.
    function automatic logic req_misaligned(input ReqDataSz size, input logic [1:0] addr_lsb);
        case (size)
            ReqDataSz16: return addr_lsb[0];
            ReqDataSz32: return (addr_lsb != 2'b00);
            ReqDataSz48: return addr_lsb[0];
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mem_responder_ram.sv
// Single-port byte-wide RAM for the Cpu memory responder.
// Combinational read, synchronous write, contents are never reset.
module cpu_mem_byte_ram #(
    parameter int MEM_BYTES = 65536,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Cpu-side memory responder: stalls the Cpu while it moves one byte per cycle to/from the local RAM.
// Define CPU_MEM_RESP_ALIGN_FAULT_EN to reject misaligned requests with a one-cycle fault in DONE.
module cpu_mem_responder
    import pkg_cpu::*;
#(
    parameter int MEM_BYTES   = 65536,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        cpu_enable,
    output logic [mem_resp_rdata_width-1:0] rdata,
    output logic        fault
);

    localparam int AW = $clog2(MEM_BYTES);

    MemRespState   state;
    MemRespState   next_state;
    logic          cap_we;
    logic [2:0]    cap_bytes;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [2:0]    byte_cnt;
    logic [3:0]    wait_cnt;
    logic [2:0]    req_bytes;
    logic          capture;
    logic          misaligned;
    logic          wait_done;
    logic          last_byte;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW];

    // A 48b-sized write is a 32b write: the write data bus is only 32 bits wide.
    assign req_bytes = (req_we && (ReqDataSz'(req_size) == ReqDataSz48))
                       ? 3'd4 : req_size_to_bytes(ReqDataSz'(req_size));

`ifdef CPU_MEM_RESP_ALIGN_FAULT_EN
    assign misaligned = req_misaligned(ReqDataSz'(req_size), req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign capture   = (state == MemRespIdle) && req_valid;
    assign wait_done = (wait_cnt == 4'(WAIT_STATES - 1));
    assign last_byte = (byte_cnt == (cap_bytes - 3'd1));
    assign ram_addr  = cap_addr + AW'(byte_cnt);
    assign ram_wdata = cap_wdata[{byte_cnt[1:0], 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MemRespIdle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            MemRespIdle: begin
                if (req_valid) begin
                    if (misaligned) begin
                        next_state = MemRespDone;
                    end else if (WAIT_STATES > 0) begin
                        next_state = MemRespWait;
                    end else begin
                        next_state = MemRespXfer;
                    end
                end
            end
            MemRespWait: begin
                if (wait_done) begin
                    next_state = MemRespXfer;
                end
            end
            MemRespXfer: begin
                if (last_byte) begin
                    next_state = MemRespDone;
                end
            end
            default: next_state = MemRespIdle;
        endcase
    end

    // In IDLE the stall follows req_valid directly so the capture cycle already counts as stalled.
    always_comb begin
        cpu_enable = 1'b0;
        ram_we     = 1'b0;
        case (state)
            MemRespIdle: cpu_enable = !req_valid;
            MemRespXfer: ram_we     = cap_we;
            MemRespDone: cpu_enable = 1'b1;
            default:     cpu_enable = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_bytes <= 3'd1;
            cap_addr  <= '0;
            cap_wdata <= '0;
            byte_cnt  <= '0;
            wait_cnt  <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                MemRespIdle: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_bytes <= req_bytes;
                        cap_addr  <= req_addr[AW-1:0];
                        cap_wdata <= req_wdata;
                        byte_cnt  <= '0;
                        wait_cnt  <= '0;
                        if (!req_we || misaligned) begin
                            rdata <= '0;
                        end
                    end
                end
                MemRespWait: begin
                    wait_cnt <= wait_cnt + 4'd1;
                end
                MemRespXfer: begin
                    if (!cap_we) begin
                        rdata[{byte_cnt, 3'b000} +: 8] <= ram_rdata;
                    end
                    byte_cnt <= last_byte ? 3'd0 : (byte_cnt + 3'd1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CPU_MEM_RESP_ALIGN_FAULT_EN
    logic fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= capture && misaligned;
        end
    end

    assign fault = fault_q;
`else
    logic unused_capture;

    assign unused_capture = capture;
    assign fault          = 1'b0;
`endif

    cpu_mem_byte_ram #(
        .MEM_BYTES(MEM_BYTES)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule
